rice_bus_sram_slave: RTL and testbench
======================================

RICE_BUS_SRAM_SLAVE -- requirements
Module: rice_bus_sram_slave

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address and data width.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning the number of XLEN-bit storage words (power of two).
REQ-003 SHALL have parameter BASE_ADDRESS, default 32'h8000_0000, meaning the byte address of word 0.
REQ-004 SHALL have parameter RESPONSE_DEPTH, default 2, meaning the maximum number of outstanding (accepted, not yet response-acked) requests; minimum 1.
REQ-005 SHALL have port i_clk, input, 1 bit, clock.
REQ-006 SHALL have port i_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port bus_if, rice_bus_if.slave modport, meaning the responder end of the bus: request_valid, request_ready, address, strobe, write_data, response_valid, response_ready, read_data.
REQ-008 SHALL have port o_error, output, 1 bit, meaning a one-cycle out-of-range pulse; present only when RICE_BUS_SRAM_ADDRESS_CHECK_EN is defined.

Function
REQ-009 SHALL define request accept as request_valid && request_ready, and response ack as response_valid && response_ready.
REQ-010 SHALL treat an accepted request as a write when strobe != 0 and as a read otherwise.
REQ-011 SHALL compute word index = ((address - BASE_ADDRESS) >> 2) modulo DEPTH and ignore address[1:0].
REQ-012 SHALL, on a write, update only the bytes whose strobe bit is 1, at the accept clock edge.
REQ-013 SHALL produce exactly one response per accepted request, in acceptance order; a read carries the stored word and a write carries read_data = 0.
REQ-014 SHALL assert response_valid in the cycle after acceptance when no older response is pending (1-cycle latency); otherwise the response is queued behind the older responses.
REQ-015 SHALL hold response_valid and read_data stable while response_ready = 0.
REQ-016 SHALL keep an outstanding counter of width $clog2(RESPONSE_DEPTH+1): +1 on accept only, -1 on response ack only, unchanged when both or neither occur.
REQ-017 SHALL drive request_ready = (outstanding < RESPONSE_DEPTH) from registered state only; it SHALL NOT depend combinationally on response_ready or request_valid.
REQ-018 SHALL sustain one accept per cycle when response_ready is held at 1 and RESPONSE_DEPTH >= 2.
REQ-019 SHALL return the newly written data to a read accepted in any cycle after the write's accept (no read-after-write hazard).
REQ-020 SHALL never drop or duplicate a response when outstanding = RESPONSE_DEPTH and response ack and a new request occur in the same cycle; the new request waits for request_ready.

Reset
REQ-021 SHALL, while i_rst_n = 0, force request_ready = 0 and response_valid = 0, clear the outstanding counter and response queue to empty, drive read_data = 0, and drive o_error (if present) = 0.
REQ-022 SHALL discard in-flight responses on reset mid-operation while retaining storage contents; the storage array SHALL NOT be reset.
REQ-023 SHALL assert request_ready in the first cycle after reset deassertion.

Configuration
REQ-024 SHALL compile address range checking in when macro RICE_BUS_SRAM_ADDRESS_CHECK_EN is defined: an address outside [BASE_ADDRESS, BASE_ADDRESS + 4*DEPTH) ignores writes, returns read_data = 0, and pulses o_error for one cycle at acceptance.
REQ-025 SHALL, without RICE_BUS_SRAM_ADDRESS_CHECK_EN, omit o_error and alias all addresses modulo DEPTH per REQ-011.

Verification
REQ-026 SHALL verify write 32'hDEAD_BEEF to 32'h8000_0010 with strobe 4'hF, then read 32'h8000_0010 -> write response read_data 0, then read response 32'hDEAD_BEEF one cycle after the read's accept.
REQ-027 SHALL verify a partial write: strobe 4'b0010 with write_data 32'h0000_AB00 over 32'h1111_1111 -> subsequent read returns 32'h1111_AB11.
REQ-028 SHALL verify back-pressure with response_ready = 0 and 3 reads issued (RESPONSE_DEPTH = 2) -> 2 accepted, request_ready = 0, read_data stable; after response_ready = 1, 3 responses arrive in order.
REQ-029 SHALL verify back-to-back reads of 8 consecutive addresses with response_ready = 1 -> 8 accepts in 8 consecutive cycles and 8 in-order responses, first response at latency 1.
REQ-030 SHALL verify reset asserted with 2 responses pending -> response_valid = 0 and request_ready = 0 during reset; after reset, a read of a previously written word returns the written value.
REQ-031 SHALL verify, with RICE_BUS_SRAM_ADDRESS_CHECK_EN defined, a write to 32'h8000_1000 (DEPTH = 1024) -> o_error pulses once and word 0 is unchanged; without the macro, the same write updates word 0.

Source files
------------

// File: rtl/rice_bus_sram_slave_if.sv
// Request/response bus between an initiator and an SRAM-style responder.
// One request per accept, one response per request, responses returned in order.
interface rice_bus_if #(
   parameter int XLEN = 32
) ();
   logic                request_valid;
   logic                request_ready;
   logic [XLEN-1:0]     address;
   logic [XLEN/8-1:0]   strobe;
   logic [XLEN-1:0]     write_data;
   logic                response_valid;
   logic                response_ready;
   logic [XLEN-1:0]     read_data;

   modport master (
      output request_valid, address, strobe, write_data, response_ready,
      input  request_ready, response_valid, read_data
   );

   modport slave (
      input  request_valid, address, strobe, write_data, response_ready,
      output request_ready, response_valid, read_data
   );
endinterface

// File: rtl/rice_bus_sram_slave.sv
// Word-addressed SRAM responder on the rice bus.
// Requests are served at the accept edge; the result (read word, or 0 for a
// write) is pushed into an in-order response queue of RESPONSE_DEPTH entries.
// The queue occupancy is the outstanding count, which alone gates request_ready.
// Optional build macro RICE_BUS_SRAM_ADDRESS_CHECK_EN: adds o_error and makes
// addresses outside the window inert (writes dropped, reads return 0).
// Without it every address aliases into the array modulo DEPTH.
module rice_bus_sram_slave #(
   parameter int              XLEN           = 32,
   parameter int              DEPTH          = 1024,
   parameter logic [XLEN-1:0] BASE_ADDRESS   = 32'h8000_0000,
   parameter int              RESPONSE_DEPTH = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   rice_bus_if.slave  bus_if
`ifdef RICE_BUS_SRAM_ADDRESS_CHECK_EN
   ,
   output logic       o_error
`endif
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW    = XLEN / 8;
   localparam int CNT_W = $clog2(RESPONSE_DEPTH + 1);
   localparam int PTR_W = (RESPONSE_DEPTH > 1) ? $clog2(RESPONSE_DEPTH) : 1;

   logic [XLEN-1:0]  mem    [DEPTH];
   logic [XLEN-1:0]  resp_q [RESPONSE_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] outstanding;

   logic             accept;
   logic             ack;
   logic             is_write;
   logic             in_range;
   logic [XLEN-1:0]  offset;
   logic [IDX_W-1:0] idx;
   logic [XLEN-1:0]  resp_data;
   logic             unused_addr_bits;

   assign offset   = bus_if.address - BASE_ADDRESS;
   assign idx      = offset[IDX_W+1:2];
   assign is_write = (bus_if.strobe != '0);

   // Byte offset bits never select anything; high bits matter only when range checking.
   assign unused_addr_bits = ^{offset[1:0], offset[XLEN-1:IDX_W+2]};

`ifdef RICE_BUS_SRAM_ADDRESS_CHECK_EN
   // Unsigned wrap of the subtraction makes addresses below BASE land far out of range too.
   assign in_range = (offset[XLEN-1:IDX_W+2] == '0);
`else
   assign in_range = 1'b1;
`endif

   // Ready comes from the registered occupancy only; held low throughout reset.
   assign bus_if.request_ready  = i_rst_n && (outstanding < CNT_W'(RESPONSE_DEPTH));
   assign bus_if.response_valid = (outstanding != '0);
   assign bus_if.read_data      = bus_if.response_valid ? resp_q[rd_ptr] : '0;

   assign accept = bus_if.request_valid && bus_if.request_ready;
   assign ack    = bus_if.response_valid && bus_if.response_ready;

   // Write responses and out-of-range reads carry zero.
   assign resp_data = (is_write || !in_range) ? '0 : mem[idx];

   // Storage array: byte-lane write at the accept edge, never reset.
   always_ff @(posedge i_clk) begin
      if (accept && is_write && in_range) begin
         for (int b = 0; b < SW; b++) begin
            if (bus_if.strobe[b]) mem[idx][b*8 +: 8] <= bus_if.write_data[b*8 +: 8];
         end
      end
   end

   // Response payload slots; validity is tracked by the pointers and count.
   always_ff @(posedge i_clk) begin
      if (accept) resp_q[wr_ptr] <= resp_data;
   end

   // Queue pointers and outstanding count; reset empties the queue.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
      end else begin
         if (accept) wr_ptr <= (wr_ptr == PTR_W'(RESPONSE_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (ack)    rd_ptr <= (rd_ptr == PTR_W'(RESPONSE_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({accept, ack})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

`ifdef RICE_BUS_SRAM_ADDRESS_CHECK_EN
   // One-cycle error pulse for each accepted out-of-range request.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_error <= 1'b0;
      else          o_error <= accept && !in_range;
   end
`endif

endmodule

// File: tb/tb_rice_bus_sram_slave.sv
// Directed bench for rice_bus_sram_slave (XLEN 32, DEPTH 1024, RESPONSE_DEPTH 2).
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_rice_bus_sram_slave;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   rice_bus_if #(.XLEN(32)) bus ();

`ifdef RICE_BUS_SRAM_ADDRESS_CHECK_EN
   logic err_o;
   int   err_pulses = 0;
`endif

   rice_bus_sram_slave #(
      .XLEN(32), .DEPTH(1024), .BASE_ADDRESS(32'h8000_0000), .RESPONSE_DEPTH(2)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus_if  (bus)
`ifdef RICE_BUS_SRAM_ADDRESS_CHECK_EN
      ,
      .o_error (err_o)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record accepts and acked responses as seen just before the edge that completes them.
   int          acc_cyc[$];
   int          rsp_cyc[$];
   logic [31:0] rsp_dat[$];
   always @(negedge clk) begin
      if (bus.request_valid && bus.request_ready) acc_cyc.push_back(cyc);
      if (bus.response_valid && bus.response_ready) begin
         rsp_cyc.push_back(cyc);
         rsp_dat.push_back(bus.read_data);
      end
`ifdef RICE_BUS_SRAM_ADDRESS_CHECK_EN
      if (err_o) err_pulses++;
`endif
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      acc_cyc.delete();
      rsp_cyc.delete();
      rsp_dat.delete();
   endtask

   // One isolated transaction with response_ready high; checks 1-cycle latency and data.
   task automatic single(input string name, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wdata, input logic [31:0] exp);
      bit got = 0;
      @(posedge clk); #1;
      bus.request_valid = 1'b1;
      bus.address       = addr;
      bus.strobe        = strb;
      bus.write_data    = wdata;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.request_ready) begin
            got = 1;
            break;
         end
      end
      @(posedge clk); #1;
      bus.request_valid = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s accept timeout: request_ready stayed 0", name);
      end else begin
         @(negedge clk);
         check({name, " valid"}, {31'd0, bus.response_valid}, 32'd1);
         check({name, " data"}, bus.read_data, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];

   initial begin
      rst_n              = 1'b0;
      bus.request_valid  = 1'b0;
      bus.address        = '0;
      bus.strobe         = '0;
      bus.write_data     = '0;
      bus.response_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst ready", {31'd0, bus.request_ready}, 32'd0);
      check("rst valid", {31'd0, bus.response_valid}, 32'd0);
      check("rst data", bus.read_data, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post rst ready", {31'd0, bus.request_ready}, 32'd1);

      // Single-transaction vectors (a read uses strobe 0)
      vecs.push_back('{"w10",     32'h8000_0010, 4'hF,    32'hDEAD_BEEF, 32'h0});
      vecs.push_back('{"r10",     32'h8000_0010, 4'h0,    32'h0,         32'hDEAD_BEEF});
      vecs.push_back('{"w20",     32'h8000_0020, 4'hF,    32'h1111_1111, 32'h0});
      vecs.push_back('{"w20 p",   32'h8000_0020, 4'b0010, 32'h0000_AB00, 32'h0});
      vecs.push_back('{"r20",     32'h8000_0020, 4'h0,    32'h0,         32'h1111_AB11});
      vecs.push_back('{"w24",     32'h8000_0024, 4'hF,    32'h0,         32'h0});
      vecs.push_back('{"w24 p",   32'h8000_0024, 4'b1001, 32'hAABB_CCDD, 32'h0});
      vecs.push_back('{"r27",     32'h8000_0027, 4'h0,    32'h0,         32'hAA00_00DD});
      vecs.push_back('{"w00",     32'h8000_0000, 4'hF,    32'hCAFE_F00D, 32'h0});
      vecs.push_back('{"w1000",   32'h8000_1000, 4'hF,    32'h1234_5678, 32'h0});
`ifdef RICE_BUS_SRAM_ADDRESS_CHECK_EN
      vecs.push_back('{"r00",     32'h8000_0000, 4'h0,    32'h0,         32'hCAFE_F00D});
      vecs.push_back('{"r1010",   32'h8000_1010, 4'h0,    32'h0,         32'h0});
`else
      vecs.push_back('{"r00",     32'h8000_0000, 4'h0,    32'h0,         32'h1234_5678});
      vecs.push_back('{"r1010",   32'h8000_1010, 4'h0,    32'h0,         32'hDEAD_BEEF});
`endif
      for (int i = 0; i < vecs.size(); i++)
         single(vecs[i].name, vecs[i].addr, vecs[i].strb, vecs[i].wdata, vecs[i].exp);

      // Back-pressure: three reads with response_ready low
      repeat (2) @(posedge clk);
      clear_mon();
      #1;
      bus.response_ready = 1'b0;
      bus.request_valid  = 1'b1;
      bus.strobe         = 4'h0;
      bus.address        = 32'h8000_0010;
      @(posedge clk); #1;
      bus.address = 32'h8000_0020;
      @(posedge clk); #1;
      bus.address = 32'h8000_0024;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp ready", {31'd0, bus.request_ready}, 32'd0);
         check("bp hold data", bus.read_data, 32'hDEAD_BEEF);
      end
      check("bp accepts", acc_cyc.size(), 32'd2);
      @(posedge clk); #1;
      bus.response_ready = 1'b1;
      for (int k = 0; k < 20 && rsp_dat.size() < 3; k++) begin
         @(posedge clk); #1;
         if (acc_cyc.size() >= 3) bus.request_valid = 1'b0;
      end
      bus.request_valid = 1'b0;
      check("bp resp count", rsp_dat.size(), 32'd3);
      if (rsp_dat.size() == 3) begin
         check("bp resp0", rsp_dat[0], 32'hDEAD_BEEF);
         check("bp resp1", rsp_dat[1], 32'h1111_AB11);
         check("bp resp2", rsp_dat[2], 32'hAA00_00DD);
      end

      // Preload eight consecutive words, then read them back to back
      for (int i = 0; i < 8; i++)
         single("burst wr", 32'h8000_0100 + 32'(4 * i), 4'hF, 32'h100 + 32'(i), 32'h0);
      @(posedge clk);
      clear_mon();
      #1;
      bus.request_valid = 1'b1;
      bus.strobe        = 4'h0;
      for (int i = 0; i < 8; i++) begin
         bus.address = 32'h8000_0100 + 32'(4 * i);
         @(posedge clk); #1;
      end
      bus.request_valid = 1'b0;
      repeat (4) @(posedge clk);
      check("burst accepts", acc_cyc.size(), 32'd8);
      check("burst resps", rsp_dat.size(), 32'd8);
      if (acc_cyc.size() == 8 && rsp_dat.size() == 8) begin
         check("burst first latency", rsp_cyc[0] - acc_cyc[0], 32'd1);
         for (int i = 0; i < 8; i++) begin
            check("burst accept cycle", acc_cyc[i] - acc_cyc[0], 32'(i));
            check("burst data", rsp_dat[i], 32'h100 + 32'(i));
         end
      end

      // Reset with two responses pending; storage must survive
      @(posedge clk); #1;
      bus.response_ready = 1'b0;
      bus.request_valid  = 1'b1;
      bus.address        = 32'h8000_0010;
      @(posedge clk); #1;
      bus.address = 32'h8000_0020;
      @(posedge clk); #1;
      bus.request_valid = 1'b0;
      @(negedge clk);
      check("pre rst pending", {31'd0, bus.response_valid}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("mid rst valid", {31'd0, bus.response_valid}, 32'd0);
      check("mid rst ready", {31'd0, bus.request_ready}, 32'd0);
      check("mid rst data", bus.read_data, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.response_ready = 1'b1;
      @(negedge clk);
      check("after rst ready", {31'd0, bus.request_ready}, 32'd1);
      check("after rst valid", {31'd0, bus.response_valid}, 32'd0);
      single("after rst r10", 32'h8000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF);

`ifdef RICE_BUS_SRAM_ADDRESS_CHECK_EN
      repeat (2) @(posedge clk);
      check("error pulses", err_pulses, 32'd2);
`endif

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
